// File: rtl/wave_gen_pkg.sv
// Shared types and sample-range helpers for the wave_gen oscillator.
// Imported by the waveform shaper and the top level.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW  = 2'd0,
    WAVE_RSAW = 2'd1,
    WAVE_TRI  = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_t;

  // Most-positive two's-complement value of a dw-bit sample.
  function automatic logic [63:0] sample_max(int dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Most-negative two's-complement value of a dw-bit sample.
  function automatic logic [63:0] sample_min(int dw);
    return 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/wave_shaper.sv
// Combinational shaper: phase index + waveform + duty -> signed sample.
// Ports: idx_i, wave_i, duty_i in; sample_o out (two's complement).
module wave_shaper
  import wave_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  wave_t                 wave_i,
  input  logic [ADDR_WIDTH-1:0] duty_i,
  output logic [DATA_WIDTH-1:0] sample_o
);

  localparam int S = DATA_WIDTH - ADDR_WIDTH;

  localparam logic [DATA_WIDTH-1:0] SMAX =
    DATA_WIDTH'(sample_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SMIN =
    DATA_WIDTH'(sample_min(DATA_WIDTH));

  logic [ADDR_WIDTH-2:0] tri_t;
  logic [DATA_WIDTH-1:0] u;

  always_comb begin
    // Fold the upper half back down so the triangle
    // rises over idx 0..127 and falls over 128..255.
    tri_t = idx_i[ADDR_WIDTH-1] ? ~idx_i[ADDR_WIDTH-2:0]
                                :  idx_i[ADDR_WIDTH-2:0];
    u = '0;
    unique case (wave_i)
      WAVE_SAW:  u = {idx_i, {S{1'b0}}};
      WAVE_RSAW: u = {~idx_i, {S{1'b0}}};
      WAVE_TRI:  u = {tri_t, {(S + 1){1'b0}}};
      WAVE_SQR:  u = '0;
    endcase
    // Offset-binary to two's complement: flip the MSB.
    if (wave_i == WAVE_SQR)
      sample_o = (idx_i < duty_i) ? SMAX : SMIN;
    else
      sample_o = {~u[DATA_WIDTH-1], u[DATA_WIDTH-2:0]};
  end

endmodule

// File: rtl/wave_gen.sv
// Phase-accumulator oscillator: saw, reverse saw, triangle, square.
// Ports: clk, reset, en, sync, freq_word, wave_sel, duty in; dout, dout_valid, wrap out.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   sync,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic [1:0]             wave_sel,
  input  logic [ADDR_WIDTH-1:0]  duty,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   wrap
);

  localparam logic [ADDR_WIDTH-1:0] DUTY_RST =
    {1'b1, {(ADDR_WIDTH - 1){1'b0}}};

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  wave_t                  wave_q, wave_d;
  logic [ADDR_WIDTH-1:0]  duty_q, duty_d;
  logic                   v1_q, v1_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   wrap_q, wrap_d;

  logic [PHASE_WIDTH-1:0] sum;
  logic                   carry;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0]  shaped;

  assign {carry, sum} = {1'b0, phase_q} + {1'b0, freq_word};
  assign idx = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];

  wave_shaper #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_shaper (
    .idx_i    (idx),
    .wave_i   (wave_q),
    .duty_i   (duty_q),
    .sample_o (shaped)
  );

  always_comb begin
    phase_d = phase_q;
    wave_d  = wave_q;
    duty_d  = duty_q;
    wrap_d  = 1'b0;
    // Mode only reloads at a sync or a carry-out so
    // a waveform switch never cuts a cycle short.
    if (sync) begin
      phase_d = '0;
      wave_d  = wave_t'(wave_sel);
      duty_d  = duty;
    end else if (en) begin
      phase_d = sum;
      wrap_d  = carry;
      if (carry) begin
        wave_d = wave_t'(wave_sel);
        duty_d = duty;
      end
    end
    v1_d    = en | sync;
    valid_d = v1_q;
    dout_d  = v1_q ? shaped : dout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      wave_q  <= WAVE_SAW;
      duty_q  <= DUTY_RST;
      v1_q    <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wave_q  <= wave_d;
      duty_q  <= duty_d;
      v1_q    <= v1_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign wrap       = wrap_q;

endmodule

// File: doc/wave_gen.md
Name: wave_gen

Overview:
- Parametrised phase-accumulator oscillator for the synth datapath. Successor to the fixed single-waveform sawtooth generator.
- Produces a signed sample on every sample-tick enable. Output is saw, reverse saw, triangle, or variable-duty square.
- Frequency is set by a tuning word. Waveform and duty changes take effect only at a phase wrap or a sync, so mode switches are glitch-free.
- Sits between the control registers (freq/mode/duty) and the mixer/DAC path.

Parameters:
- DATA_WIDTH, 16, sample width; two's-complement output. Must be > ADDR_WIDTH.
- PHASE_WIDTH, 24, phase accumulator width. Must be >= ADDR_WIDTH.
- ADDR_WIDTH, 8, waveform index width (top bits of phase); also the duty width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  sample tick; the phase advances once per cycle with en=1
- sync  in  1  hard sync; phase forced to 0
- freq_word  in  PHASE_WIDTH  phase increment per tick, unsigned
- wave_sel  in  2  requested waveform (wave_t)
- duty  in  ADDR_WIDTH  requested square high-time threshold
- dout  out  DATA_WIDTH  signed sample, registered
- dout_valid  out  1  one-cycle pulse; new dout present
- wrap  out  1  one-cycle pulse; the phase update carried out of the MSB

Behaviour:
- Reset (synchronous, all registers, overrides everything):
  - phase=0, wave_act=WAVE_SAW, duty_act=2^(ADDR_WIDTH-1).
  - v1=0, dout=0, dout_valid=0, wrap=0.
- Phase update at edge k:
  - sync=1: phase<=0, wrap<=0. sync takes priority over en, and the add is skipped.
  - else en=1: phase<=(phase+freq_word) mod 2^PHASE_WIDTH; wrap<=carry-out.
  - else: phase holds, wrap<=0.
- Mode reload: wave_act<=wave_sel and duty_act<=duty at the same edge as a carry-out update or any sync (with or without en). At all other times wave_sel and duty are ignored.
- Pipeline and latency:
  - v1<=en|sync.
  - At edge k+1, if v1=1: dout<=shape(idx, wave_act, duty_act); otherwise dout holds.
  - dout_valid<=v1.
  - A tick at edge k gives a valid sample after edge k+1: latency 2 edges, one sample per tick, back-to-back ticks supported.
- Sample index: idx = phase[PHASE_WIDTH-1 -: ADDR_WIDTH]. S = DATA_WIDTH-ADDR_WIDTH. Offset-binary value u is converted by inverting the MSB (equal to u-2^(DATA_WIDTH-1)).
- Waveforms:
  - WAVE_SAW: u = idx<<S. idx=0 -> 0x8000; idx=255 -> 0x7F00.
  - WAVE_RSAW: u = (~idx)<<S. idx=0 -> 0x7F00; idx=255 -> 0x8000.
  - WAVE_TRI: t = idx[MSB] ? ~idx[ADDR_WIDTH-2:0] : idx[ADDR_WIDTH-2:0]; u = t<<(S+1).
    - idx=0 -> 0x8000; idx=127 -> 0x7E00; idx=128 -> 0x7E00; idx=255 -> 0x8000.
  - WAVE_SQR: dout = (idx < duty_act) ? most-positive (0x7FFF) : most-negative (0x8000).
    - duty_act=0 gives constant 0x8000; duty_act=128 gives 50%.
- Boundaries:
  - freq_word=0: phase frozen, dout constant, dout_valid still pulses per tick, no wrap.
  - freq_word >= 2^PHASE_WIDTH-1 is legal (aliasing is accepted); the carry-out still flags wrap.
  - sync and en in the same cycle: sample at phase 0 with the freshly loaded mode; wrap=0.
  - Reset mid-pipeline: pending v1 is discarded; no dout_valid follows reset.
  - wave_sel/duty changes between wraps: no effect on output until the next wrap or sync.

Decomposition:
- Package wave_gen_pkg:
  - typedef enum logic[1:0] wave_t {WAVE_SAW=0, WAVE_RSAW=1, WAVE_TRI=2, WAVE_SQR=3}.
  - Function/constants for the most-positive and most-negative sample per DATA_WIDTH.
- Sub-module wave_shaper: purely combinational (idx, wave_t, duty -> signed sample). The top level owns the phase, the mode registers and the pipeline.

Test Plan (defaults; freq_word=0x010000 gives idx +1 per tick):
1. Reset then 3 ticks in SAW -> dout_valid pulses 2 edges after each tick. Samples are 0x8100, 0x8200, 0x8300. During reset, dout=0 and dout_valid=0.
2. 256 consecutive ticks -> wrap pulses exactly once, on the 256th update. The next sample is 0x8000. freq_word=0 -> samples stay constant and wrap never fires.
3. Set wave_sel=SQR, duty=64 mid-cycle -> output stays SAW until the wrap. From then: 0x7FFF for idx 0..63, 0x8000 for idx 64..255 (25% duty).
4. TRI sweep over idx 0..255 -> peaks 0x7E00 at idx 127 and 128. Returns 0x8000 at idx 255. Monotonic rise, then monotonic fall.
5. sync asserted together with en at phase idx 0x5A, wave_sel=RSAW -> next sample 0x7F00, wrap=0, mode takes effect immediately.
6. reset asserted one cycle after a tick -> no dout_valid follows. Outputs and phase match their reset values at the next edge.
